// File: rtl/powerup_effects_if.sv
// powerup_effects_if: power-up pulses in, effect levels, credits and req/ack handshakes out
// master drives pulses, clear, tick, fire and acks; slave (powerup_effects) drives effect levels, counters and requests
interface powerup_effects_if #(
  parameter int SHOT_W = 4
);
  logic clear, tick;
  logic paddle_size, paddle_speed, give_ball, ball_speed, ball_size, ball_display, get_shot, drop_block;
  logic fire, ball_ack, drop_ack;
  logic paddle_wide, paddle_fast, ball_fast, ball_big, ball_hidden;
  logic [SHOT_W-1:0] shots_left;
  logic shot_ready, ball_req, drop_req;
  logic [1:0] balls_pending;
  modport master (
    output clear, tick, paddle_size, paddle_speed, give_ball, ball_speed, ball_size, ball_display,
           get_shot, drop_block, fire, ball_ack, drop_ack,
    input  paddle_wide, paddle_fast, ball_fast, ball_big, ball_hidden, shots_left, shot_ready,
           ball_req, balls_pending, drop_req
  );
  modport slave (
    input  clear, tick, paddle_size, paddle_speed, give_ball, ball_speed, ball_size, ball_display,
           get_shot, drop_block, fire, ball_ack, drop_ack,
    output paddle_wide, paddle_fast, ball_fast, ball_big, ball_hidden, shots_left, shot_ready,
           ball_req, balls_pending, drop_req
  );
endinterface

// File: rtl/powerup_effects.sv
// powerup_effects: turns one-cycle power-up pulses into timed effects, shot budget, ball credits and drop request
// ports: clock, reset (async active-high), bus (slave: pulses/clear/tick/acks in, effects/counters/requests out)
module powerup_effects #(
  parameter int DUR_W      = 10,
  parameter int DURATION   = 600,
  parameter int SHOT_W     = 4,
  parameter int SHOT_COUNT = 8,
  parameter int MAX_BALLS  = 3
) (
  input logic clock,
  input logic reset,
  powerup_effects_if.slave bus
);
  logic [4:0] pulse, active;
  logic [SHOT_W-1:0] shots;
  logic [1:0] balls;
  logic drop;
  assign pulse = {bus.ball_display, bus.ball_size, bus.ball_speed, bus.paddle_speed, bus.paddle_size};
  for (genvar i = 0; i < 5; i++) begin : g_fx
    logic [DUR_W-1:0] t;
    always_ff @(posedge clock or posedge reset)
      if (reset) t <= '0;
      else if (bus.clear) t <= '0;
      else if (pulse[i]) t <= DUR_W'(DURATION);
      else if (bus.tick && t != '0) t <= t - 1'b1;
    assign active[i] = t != '0;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) shots <= '0;
    else if (bus.clear) shots <= '0;
    else if (bus.get_shot) shots <= SHOT_W'(SHOT_COUNT);
    else if (bus.fire && shots != '0) shots <= shots - 1'b1;
  // give and ack together cancel out, so only one of them alone moves the count
  always_ff @(posedge clock or posedge reset)
    if (reset) balls <= '0;
    else if (bus.clear) balls <= '0;
    else if (bus.give_ball && !bus.ball_ack) balls <= balls == 2'(MAX_BALLS) ? balls : balls + 2'd1;
    else if (bus.ball_ack && !bus.give_ball && balls != '0) balls <= balls - 2'd1;
  // a new drop request outranks an ack arriving in the same cycle
  always_ff @(posedge clock or posedge reset)
    if (reset) drop <= 1'b0;
    else if (bus.clear) drop <= 1'b0;
    else if (bus.drop_block) drop <= 1'b1;
    else if (bus.drop_ack) drop <= 1'b0;
  assign {bus.ball_hidden, bus.ball_big, bus.ball_fast, bus.paddle_fast, bus.paddle_wide} = active;
  assign bus.shots_left = shots;
  assign bus.shot_ready = shots != '0;
  assign bus.balls_pending = balls;
  assign bus.ball_req = balls != '0;
  assign bus.drop_req = drop;
endmodule

// File: tb/tb_powerup_effects.sv
// tb_powerup_effects: vector table, hand sequences and randomized run against a reference model
module tb_powerup_effects;
  localparam int DUR = 4, SC = 3, MB = 3;
  localparam logic [12:0] CLR = 13'd1 << 0, TICK = 13'd1 << 1, PS = 13'd1 << 2, PSPD = 13'd1 << 3,
    GB = 13'd1 << 4, BSPD = 13'd1 << 5, BSZ = 13'd1 << 6, BD = 13'd1 << 7, GS = 13'd1 << 8,
    DROP = 13'd1 << 9, FIRE = 13'd1 << 10, BACK = 13'd1 << 11, DACK = 13'd1 << 12;
  localparam logic [12:0] ALLFX = PS | PSPD | BSPD | BSZ | BD;
  typedef struct {
    logic [12:0] inp;
    logic [4:0] fx;
    int sh;
    int bl;
    bit dr;
  } vec_t;
  vec_t tbl[$];
  logic clock = 1'b0, reset = 1'b0;
  int n_chk = 0, n_fail = 0;
  int rem[5];
  int m_shots, m_balls;
  bit m_drop;
  always #5 clock = ~clock;
  powerup_effects_if #(.SHOT_W(4)) bus ();
  powerup_effects #(.DUR_W(10), .DURATION(DUR), .SHOT_W(4), .SHOT_COUNT(SC), .MAX_BALLS(MB)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );
  task automatic drive(input logic [12:0] v);
    bus.clear = v[0]; bus.tick = v[1]; bus.paddle_size = v[2]; bus.paddle_speed = v[3];
    bus.give_ball = v[4]; bus.ball_speed = v[5]; bus.ball_size = v[6]; bus.ball_display = v[7];
    bus.get_shot = v[8]; bus.drop_block = v[9]; bus.fire = v[10]; bus.ball_ack = v[11]; bus.drop_ack = v[12];
  endtask
  task automatic model_reset();
    for (int e = 0; e < 5; e++) rem[e] = 0;
    m_shots = 0; m_balls = 0; m_drop = 0;
  endtask
  task automatic model(input logic [12:0] v);
    logic [4:0] p;
    p = {v[7], v[6], v[5], v[3], v[2]};
    if (v[0]) begin
      model_reset();
      return;
    end
    for (int e = 0; e < 5; e++)
      if (p[e]) rem[e] = DUR;
      else if (v[1] && rem[e] > 0) rem[e] = rem[e] - 1;
    if (v[8]) m_shots = SC;
    else if (v[10] && m_shots > 0) m_shots = m_shots - 1;
    if (v[4] && !v[11]) m_balls = (m_balls < MB) ? m_balls + 1 : MB;
    else if (v[11] && !v[4] && m_balls > 0) m_balls = m_balls - 1;
    if (v[9]) m_drop = 1;
    else if (v[12]) m_drop = 0;
  endtask
  task automatic step(input logic [12:0] v);
    drive(v);
    @(posedge clock);
    #1;
    drive('0);
    model(v);
  endtask
  task automatic cmp(input string n, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  task automatic check(input string tag, input logic [4:0] fx, input int sh, input int bl, input bit dr);
    cmp({tag, "/effects"}, int'({bus.ball_hidden, bus.ball_big, bus.ball_fast, bus.paddle_fast, bus.paddle_wide}), int'(fx));
    cmp({tag, "/shots_left"}, int'(bus.shots_left), sh);
    cmp({tag, "/shot_ready"}, int'(bus.shot_ready), int'(sh != 0));
    cmp({tag, "/balls_pending"}, int'(bus.balls_pending), bl);
    cmp({tag, "/ball_req"}, int'(bus.ball_req), int'(bl != 0));
    cmp({tag, "/drop_req"}, int'(bus.drop_req), int'(dr));
  endtask
  task automatic check_model(input string tag);
    logic [4:0] fx;
    for (int e = 0; e < 5; e++) fx[e] = rem[e] > 0;
    check(tag, fx, m_shots, m_balls, m_drop);
  endtask
  task automatic add(input logic [12:0] inp, input logic [4:0] fx, input int sh, input int bl, input bit dr);
    vec_t r;
    r.inp = inp; r.fx = fx; r.sh = sh; r.bl = bl; r.dr = dr;
    tbl.push_back(r);
  endtask
  initial begin
    add(GS, 0, 3, 0, 0);        add(FIRE, 0, 2, 0, 0);      add(FIRE, 0, 1, 0, 0);
    add(FIRE, 0, 0, 0, 0);      add(FIRE, 0, 0, 0, 0);      add(GS | FIRE, 0, 3, 0, 0);
    add(GB, 0, 3, 1, 0);        add(GB, 0, 3, 2, 0);        add(GB, 0, 3, 3, 0);
    add(GB, 0, 3, 3, 0);        add(GB, 0, 3, 3, 0);        add(GB | BACK, 0, 3, 3, 0);
    add(BACK, 0, 3, 2, 0);      add(BACK, 0, 3, 1, 0);      add(BACK, 0, 3, 0, 0);
    add(BACK, 0, 3, 0, 0);      add(DROP, 0, 3, 0, 1);      add(DROP, 0, 3, 0, 1);
    add('0, 0, 3, 0, 1);        add(DACK, 0, 3, 0, 0);      add(DACK, 0, 3, 0, 0);
    add(DROP | DACK, 0, 3, 0, 1);
    add(BSZ, 5'b01000, 3, 0, 1);         add(TICK, 5'b01000, 3, 0, 1);   add(TICK, 5'b01000, 3, 0, 1);
    add(BSZ | TICK, 5'b01000, 3, 0, 1);  add(TICK, 5'b01000, 3, 0, 1);   add(TICK, 5'b01000, 3, 0, 1);
    add(TICK, 5'b01000, 3, 0, 1);        add(TICK, 5'b00000, 3, 0, 1);   add(TICK, 5'b00000, 3, 0, 1);
    add(CLR | GS | PS | GB | DROP, 0, 0, 0, 0);
    drive('0);
    model_reset();
    #1 reset = 1'b1;
    #1 check("reset", 0, 0, 0, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    foreach (tbl[k]) begin
      step(tbl[k].inp);
      check($sformatf("vec%0d", k), tbl[k].fx, tbl[k].sh, tbl[k].bl, tbl[k].dr);
    end
    // paddle_wide lasts exactly four spaced ticks
    step(PS);
    cmp("wide_start", int'(bus.paddle_wide), 1);
    for (int k = 0; k < 4; k++) begin
      step('0);
      step('0);
      cmp($sformatf("wide_gap%0d", k), int'(bus.paddle_wide), 1);
      step(TICK);
      cmp($sformatf("wide_tick%0d", k), int'(bus.paddle_wide), int'(k < 3));
    end
    // everything active, then synchronous clear
    step(ALLFX | GS | GB | DROP);
    step(GB);
    check("loaded", 5'b11111, 3, 2, 1);
    step(CLR);
    check("clear", 0, 0, 0, 0);
    // everything active, then asynchronous reset between clock edges
    step(ALLFX | GS | GB | DROP);
    step(GB);
    check("loaded2", 5'b11111, 3, 2, 1);
    #3 reset = 1'b1;
    #1 check("async_reset", 0, 0, 0, 0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      logic [12:0] v;
      v = '0;
      v[0] = $urandom_range(0, 63) == 0;
      v[1] = $urandom_range(0, 2) == 0;
      foreach (v[b]) if (b >= 2 && b <= 9) v[b] = $urandom_range(0, 11) == 0;
      v[10] = $urandom_range(0, 3) == 0;
      v[11] = $urandom_range(0, 3) == 0;
      v[12] = $urandom_range(0, 3) == 0;
      step(v);
      check_model($sformatf("rnd%0d", k));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
